// File: rtl/y_window_pkg.sv
// Shared filter constants and helpers for the separable 5x5 smoothing stages.
package y_window_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned H0_DEF = 6;
    localparam int unsigned H1_DEF = 58;
    localparam int unsigned H2_DEF = 128;
    localparam int unsigned RND_C  = 128;
    localparam int unsigned SUM_W  = 17;

    // Counter width able to index n entries (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/y_column_store.sv
// Per-column history of the four previous rows; newest row in the top byte.
module y_column_store
    import y_window_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = cnt_w(DEPTH)
) (
    input  logic                 i_clock,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic [PIX_W-1:0]     i_shift_in,
    output logic [4*PIX_W-1:0]   o_rdata
);

    logic [4*PIX_W-1:0] r_mem [DEPTH];

    // Contents are never cleared; the row counter masks stale columns.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= {i_shift_in, r_mem[i_addr][4*PIX_W-1:PIX_W]};
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/y_window.sv
// Vertical 5-tap symmetric low-pass filter over a raster pixel stream, 3-clock latency.
module y_window
    import y_window_pkg::*;
#(
    parameter int unsigned WIDTH = 640,
    parameter int unsigned H0    = H0_DEF,
    parameter int unsigned H1    = H1_DEF,
    parameter int unsigned H2    = H2_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [PIX_W-1:0]  i_din,
    input  logic              i_validin,
    input  logic              i_sof,
    output logic [PIX_W-1:0]  o_dout,
    output logic              o_validout
);

    localparam int unsigned CW        = cnt_w(WIDTH);
    localparam int unsigned RW        = 3;
    localparam int unsigned FULL_ROWS = 4;
    localparam int unsigned AW1       = PIX_W + 1;

    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [CW-1:0]      w_col_eff;
    logic [RW-1:0]      w_row_eff;
    logic               w_last;
    logic [4*PIX_W-1:0] w_rd;
    logic [PIX_W-1:0]   w_p1, w_p2, w_p3, w_p4;

    logic [AW1-1:0]     r_a, r_b;
    logic [PIX_W-1:0]   r_c;
    logic               r_v1, r_w1;
    logic [SUM_W-1:0]   r_m;
    logic               r_v2, r_w2;
    logic [PIX_W-1:0]   r_s;
    logic               r_v3, r_w3;
    logic [SUM_W:0]     w_rnd;
    logic [PIX_W-1:0]   w_sat;

    // A sof pixel is forced to row 0, column 0.
    assign w_col_eff = i_sof ? '0 : r_col;
    assign w_row_eff = i_sof ? '0 : r_row;
    assign w_last    = (w_col_eff == CW'(WIDTH - 1));

    y_column_store #(
        .DEPTH (WIDTH),
        .AW    (CW)
    ) u_store (
        .i_clock    (i_clock),
        .i_we       (i_validin),
        .i_addr     (w_col_eff),
        .i_shift_in (i_din),
        .o_rdata    (w_rd)
    );

    assign w_p1 = w_rd[4*PIX_W-1:3*PIX_W];
    assign w_p2 = w_rd[3*PIX_W-1:2*PIX_W];
    assign w_p3 = w_rd[2*PIX_W-1:PIX_W];
    assign w_p4 = w_rd[PIX_W-1:0];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_validin) begin
            if (w_last) begin
                r_col <= '0;
                r_row <= (w_row_eff == RW'(FULL_ROWS)) ? w_row_eff : w_row_eff + RW'(1);
            end else begin
                r_col <= w_col_eff + CW'(1);
                r_row <= w_row_eff;
            end
        end
    end

    // Rounded, saturated output of the weighted sum.
    assign w_rnd = {1'b0, r_m} + (SUM_W + 1)'(RND_C);
    assign w_sat = (|w_rnd[SUM_W:2*PIX_W]) ? '1 : w_rnd[2*PIX_W-1:PIX_W];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_v1       <= 1'b0;
            r_w1       <= 1'b0;
            r_m        <= '0;
            r_v2       <= 1'b0;
            r_w2       <= 1'b0;
            r_s        <= '0;
            r_v3       <= 1'b0;
            r_w3       <= 1'b0;
            o_dout     <= '0;
            o_validout <= 1'b0;
        end else begin
            r_v1 <= i_validin;
            r_w1 <= i_validin && (w_row_eff == RW'(FULL_ROWS));
            if (i_validin) begin
                r_a <= AW1'(i_din) + AW1'(w_p4);
                r_b <= AW1'(w_p1) + AW1'(w_p3);
                r_c <= w_p2;
            end

            r_v2 <= r_v1;
            r_w2 <= r_w1;
            r_m  <= SUM_W'(r_a) * SUM_W'(H0) + SUM_W'(r_b) * SUM_W'(H1)
                  + SUM_W'(r_c) * SUM_W'(H2);

            r_v3 <= r_v2;
            r_w3 <= r_w2;
            if (r_v2) begin
                r_s <= w_sat;
            end

            o_validout <= r_v3 && r_w3;
            if (r_v3) begin
                o_dout <= r_s;
            end
        end
    end

endmodule

// File: tb/tb_y_window.sv
// Randomized/directed bench for y_window against a row-history reference model.
module tb_y_window;

    localparam int unsigned W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'd0;
    logic       validin = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] dout;
    logic       validout;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hist[8][W];
    int   m_row = 0;
    int   m_col = 0;

    always #5 clk = ~clk;

    y_window #(
        .WIDTH (W)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_din      (din),
        .i_validin  (validin),
        .i_sof      (sof),
        .o_dout     (dout),
        .o_validout (validout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        m_row = 0;
        m_col = 0;
        q.delete();
    endfunction

    // Vertical 5-tap filter on the centre row, two rows above the input row.
    function automatic void model_accept(input bit s, input int d);
        int x0, x1, x2, x3, x4, m, r;
        if (s) begin
            m_row = 0;
            m_col = 0;
        end
        hist[m_row % 8][m_col] = d;
        if (m_row >= 4) begin
            x0 = hist[m_row % 8][m_col];
            x1 = hist[(m_row - 1) % 8][m_col];
            x2 = hist[(m_row - 2) % 8][m_col];
            x3 = hist[(m_row - 3) % 8][m_col];
            x4 = hist[(m_row - 4) % 8][m_col];
            m  = 6 * (x0 + x4) + 58 * (x1 + x3) + 128 * x2;
            r  = (m + 128) / 256;
            if (r > 255) r = 255;
            q.push_back('{due: cyc + 3, val: r});
        end
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row++;
        end
    endfunction

    task automatic check_out();
        if (q.size() > 0 && q[0].due == cyc) begin
            check("validout", 32'(validout), 32'd1);
            check("dout", 32'(dout), 32'(q[0].val));
            void'(q.pop_front());
        end else begin
            check("validout_idle", 32'(validout), 32'd0);
        end
    endtask

    task automatic step(input bit v, input bit s, input int d);
        validin = v;
        sof     = s;
        din     = d[7:0];
        @(posedge clk);
        cyc++;
        if (v) model_accept(s, d);
        @(negedge clk);
        check_out();
    endtask

    // mode 0: constant val, 1: random, 2: impulse at row 2 / col 1. gap 0 none, 1 alternate, 2 random.
    task automatic frame(input int rows, input int mode, input int val, input bit sof_first, input int gap);
        int d;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < int'(W); c++) begin
                case (mode)
                    0:       d = val;
                    1:       d = int'($urandom_range(0, 255));
                    default: d = (r == 2 && c == 1) ? 255 : 0;
                endcase
                step(1'b1, sof_first && r == 0 && c == 0, d);
                if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                    step(1'b0, 1'b0, int'($urandom_range(0, 255)));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, int'($urandom_range(0, 255)));
    endtask

    initial begin
        // Reset held low with random traffic: outputs stay cleared.
        for (int i = 0; i < 6; i++) begin
            validin = 1'($urandom_range(0, 1));
            sof     = 1'($urandom_range(0, 1));
            din     = 8'($urandom_range(0, 255));
            @(posedge clk);
            @(negedge clk);
            check("rst_dout", 32'(dout), 32'd0);
            check("rst_validout", 32'(validout), 32'd0);
        end
        validin = 1'b0;
        sof     = 1'b0;
        rst_n   = 1'b1;
        model_clear();

        // Three rows after reset: no output.
        frame(3, 1, 0, 1'b0, 0);
        idle(4);

        // Flat, saturated and impulse frames.
        frame(6, 0, 100, 1'b1, 0);
        frame(6, 0, 255, 1'b1, 0);
        frame(7, 2, 0, 1'b1, 0);
        idle(4);

        // Gapped flat frame, then random data with random gaps.
        frame(6, 0, 100, 1'b1, 1);
        frame(8, 1, 0, 1'b1, 2);

        // sof at a row boundary and mid-row.
        frame(5, 1, 0, 1'b1, 0);
        frame(6, 1, 0, 1'b1, 0);
        frame(5, 1, 0, 1'b1, 0);
        step(1'b1, 1'b0, int'($urandom_range(0, 255)));
        step(1'b1, 1'b0, int'($urandom_range(0, 255)));
        frame(6, 1, 0, 1'b1, 2);

        // Async reset mid-row while an output is being presented.
        frame(5, 1, 0, 1'b1, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, int'($urandom_range(0, 255)));
        validin = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_validout", 32'(validout), 32'd0);
        check("async_dout", 32'(dout), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        frame(6, 1, 0, 1'b0, 0);

        idle(6);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
